mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (icache, dcache) sharing one RAM port.
// Dcache has priority; a bounded starvation counter guarantees icache forward progress.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_load,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_store,
  output logic        d_ready,
  output logic [31:0] d_load,
  input  logic        halt,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ack,
  output logic        arb_idle
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, XFER_I, XFER_D, RESP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic [31:0]   i_load_q, i_load_d;
  logic [31:0]   d_load_q, d_load_d;
  logic          wr_q, wr_d;
  logic          side_d_q, side_d_d;   // 1: current access belongs to the dcache

  logic d_req, i_elig;
  assign d_req  = d_ren | d_wen;
  assign i_elig = i_ren & ~halt;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    store_d  = store_q;
    i_load_d = i_load_q;
    d_load_d = d_load_q;
    wr_d     = wr_q;
    side_d_d = side_d_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_elig || starve_q < SW'(STARVE_MAX))) begin
          state_d  = XFER_D;
          addr_d   = d_addr;
          store_d  = d_store;
          wr_d     = d_wen;
          side_d_d = 1'b1;
          if (!i_elig)
            starve_d = '0;
          else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
        end else if (i_elig) begin
          state_d  = XFER_I;
          addr_d   = i_addr;
          wr_d     = 1'b0;
          side_d_d = 1'b0;
          starve_d = '0;
        end
      end
      XFER_I: begin
        if (ram_ack) begin
          i_load_d = ram_load;
          state_d  = RESP;
        end
      end
      XFER_D: begin
        if (ram_ack) begin
          if (!wr_q) d_load_d = ram_load;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      i_load_q <= '0;
      d_load_q <= '0;
      wr_q     <= 1'b0;
      side_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      i_load_q <= i_load_d;
      d_load_q <= d_load_d;
      wr_q     <= wr_d;
      side_d_q <= side_d_d;
    end
  end

  // All RAM-facing and completion outputs decode registered state only.
  assign ram_ren   = (state_q == XFER_I) | ((state_q == XFER_D) & ~wr_q);
  assign ram_wen   = (state_q == XFER_D) & wr_q;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;
  assign i_ready   = (state_q == RESP) & ~side_d_q;
  assign d_ready   = (state_q == RESP) & side_d_q;
  assign i_load    = i_load_q;
  assign d_load    = d_load_q;
  assign arb_idle  = (state_q == IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table, starvation-order sequence and randomized run
// checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        i_ren = 1'b0, d_ren = 1'b0, d_wen = 1'b0, halt = 1'b0, ram_ack = 1'b0;
  logic [31:0] i_addr = 32'h100, d_addr = 32'h40, d_store = 32'h12345678, ram_load = '0;
  logic        i_ready, d_ready, ram_ren, ram_wen, arb_idle;
  logic [31:0] i_load, d_load, ram_addr, ram_store;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .i_ren(i_ren), .i_addr(i_addr), .i_ready(i_ready), .i_load(i_load),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_ready(d_ready), .d_load(d_load), .halt(halt),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ack(ram_ack), .arb_idle(arb_idle)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flags = {idle, ren, wen, i_ready, d_ready}
  typedef struct {
    logic        rst, i_ren, halt, d_ren, d_wen, ack;
    logic [31:0] load;
    logic [4:0]  e_flags;
    logic [31:0] e_addr, e_iload, e_dload;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input logic [31:0] load, input logic [4:0] f,
                              input logic [31:0] a, input logic [31:0] il, input logic [31:0] dl);
    vec_t v;
    {v.rst, v.i_ren, v.halt, v.d_ren, v.d_wen, v.ack} = in;
    v.load = load; v.e_flags = f; v.e_addr = a; v.e_iload = il; v.e_dload = dl;
    return v;
  endfunction

  // Reference model: one outstanding transaction, tracked as phase 0 free / 1 on bus / 2 answering.
  int          m_phase, m_dwins;
  bit          m_is_d, m_wr;
  logic [31:0] m_addr, m_store, m_iload, m_dload;

  task automatic model_step();
    bit ie, dq;
    ie = i_ren && !halt;
    dq = d_ren || d_wen;
    if (RST) begin
      m_phase = 0; m_dwins = 0; m_is_d = 0; m_wr = 0;
      m_addr = 0; m_store = 0; m_iload = 0; m_dload = 0;
    end else if (m_phase == 0) begin
      if (dq && !(ie && m_dwins == STARVE_MAX)) begin
        m_phase = 1; m_is_d = 1; m_wr = d_wen; m_addr = d_addr; m_store = d_store;
        m_dwins = ie ? m_dwins + 1 : 0;
      end else if (ie) begin
        m_phase = 1; m_is_d = 0; m_wr = 0; m_addr = i_addr; m_dwins = 0;
      end
    end else if (m_phase == 1) begin
      if (ram_ack) begin
        if (!m_is_d) m_iload = ram_load;
        else if (!m_wr) m_dload = ram_load;
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  vec_t vecs[$];

  initial begin
    bit exp_g[10];
    bit got_g[$];
    int scnt;
    logic [4:0] ef;

    vecs.push_back(mk(6'b100000, 0, 5'b10000, 32'h0,   0, 0));
    vecs.push_back(mk(6'b010000, 0, 5'b01000, 32'h100, 0, 0));
    vecs.push_back(mk(6'b010001, 32'hDEADBEEF, 5'b00010, 32'h100, 32'hDEADBEEF, 0));
    vecs.push_back(mk(6'b000000, 0, 5'b10000, 32'h100, 32'hDEADBEEF, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(6'b000110, 0, 5'b00100, 32'h40, 32'hDEADBEEF, 0));
    vecs.push_back(mk(6'b000111, 32'hFFFFFFFF, 5'b00001, 32'h40, 32'hDEADBEEF, 0));
    vecs.push_back(mk(6'b000001, 32'h77, 5'b10000, 32'h40, 32'hDEADBEEF, 0));
    vecs.push_back(mk(6'b000001, 32'h55, 5'b10000, 32'h40, 32'hDEADBEEF, 0));
    vecs.push_back(mk(6'b000100, 0, 5'b01000, 32'h40, 32'hDEADBEEF, 0));
    vecs.push_back(mk(6'b000101, 32'hCAFEF00D, 5'b00001, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(6'b000000, 0, 5'b10000, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(6'b011000, 0, 5'b10000, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(6'b011000, 0, 5'b10000, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(6'b011100, 0, 5'b01000, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D));
    vecs.push_back(mk(6'b111100, 0, 5'b10000, 32'h0, 0, 0));
    vecs.push_back(mk(6'b010100, 0, 5'b01000, 32'h40, 0, 0));
    vecs.push_back(mk(6'b010101, 32'h11, 5'b00001, 32'h40, 0, 32'h11));
    vecs.push_back(mk(6'b010000, 0, 5'b10000, 32'h40, 0, 32'h11));
    vecs.push_back(mk(6'b010000, 0, 5'b01000, 32'h100, 0, 32'h11));
    vecs.push_back(mk(6'b001000, 0, 5'b01000, 32'h100, 0, 32'h11));
    vecs.push_back(mk(6'b000001, 32'h22, 5'b00010, 32'h100, 32'h22, 32'h11));
    vecs.push_back(mk(6'b000000, 0, 5'b10000, 32'h100, 32'h22, 32'h11));

    @(negedge CLK);
    foreach (vecs[n]) begin
      {RST, i_ren, halt, d_ren, d_wen, ram_ack} = {vecs[n].rst, vecs[n].i_ren, vecs[n].halt,
                                                  vecs[n].d_ren, vecs[n].d_wen, vecs[n].ack};
      ram_load = vecs[n].load;
      @(negedge CLK);
      ef = {arb_idle, ram_ren, ram_wen, i_ready, d_ready};
      chk($sformatf("vec%0d", n), {ef, ram_addr, i_load, d_load},
          {vecs[n].e_flags, vecs[n].e_addr, vecs[n].e_iload, vecs[n].e_dload});
      if (vecs[n].e_flags[2]) chk($sformatf("vec%0d_store", n), ram_store, 32'h12345678);
    end

    // Both sides held, ack on the third strobe cycle: D x4, I, then the pattern repeats.
    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    {i_ren, halt, d_ren, d_wen, ram_ack} = 5'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; i_ren = 1'b1; d_ren = 1'b1;
    scnt = 0;
    for (int c = 0; c < 300 && got_g.size() < 10; c++) begin
      @(negedge CLK);
      if (ram_ren || ram_wen) begin
        if (scnt == 0) got_g.push_back(ram_addr == 32'h40);
        ram_ack = (scnt == 2);
        scnt++;
      end else begin
        ram_ack = 1'b0;
        scnt = 0;
      end
    end
    chk("starve_grant_count", got_g.size(), 10);
    for (int g = 0; g < 10 && g < got_g.size(); g++)
      chk($sformatf("starve_grant%0d_is_d", g), got_g[g], exp_g[g]);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      RST     = (c == 0) || ($urandom_range(0, 63) == 0);
      i_ren   = ($urandom_range(0, 2) != 0);
      halt    = ($urandom_range(0, 3) == 0);
      d_ren   = ($urandom_range(0, 2) == 0);
      d_wen   = ($urandom_range(0, 3) == 0);
      ram_ack = $urandom_range(0, 1);
      i_addr  = $urandom; d_addr = $urandom; d_store = $urandom; ram_load = $urandom;
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      ef = {m_phase == 0, m_phase == 1 && !(m_is_d && m_wr), m_phase == 1 && m_is_d && m_wr,
            m_phase == 2 && !m_is_d, m_phase == 2 && m_is_d};
      chk($sformatf("rand%0d", c), {arb_idle, ram_ren, ram_wen, i_ready, d_ready, ram_addr, i_load, d_load},
          {ef, m_addr, m_iload, m_dload});
      if (ef[2]) chk($sformatf("rand%0d_store", c), ram_store, m_store);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
